// File: rtl/knn_vote_pkg.sv
// rtl/knn_vote_pkg.sv - shared state encoding and width helper for the k-NN vote reader
package knn_vote_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_COUNT = 3'd2;
   localparam logic [2:0] ST_PICK  = 3'd3;
   localparam logic [2:0] ST_FIN   = 3'd4;

   // Index/counter width, never below one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/knn_class_hist.sv
// rtl/knn_class_hist.sv - per-class label counters with clear, increment and read ports
module knn_class_hist #(
   parameter int N_CLASSES = 16,
   parameter int CNT_W     = 4,
   parameter int CLS_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc_en,
   input  logic [CLS_W-1:0] i_inc_cls,
   output logic [CNT_W-1:0] o_inc_cnt,
   input  logic [CLS_W-1:0] i_rd_cls,
   output logic [CNT_W-1:0] o_rd_cnt
);

   logic [CNT_W-1:0] r_cnt [N_CLASSES];

   // Post-increment value, so the caller can update its running maximum in the same cycle.
   assign o_inc_cnt = r_cnt[i_inc_cls] + CNT_W'(1);
   assign o_rd_cnt  = r_cnt[i_rd_cls];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CLASSES; i++) r_cnt[i] <= '0;
      end else if (i_clr) begin
         for (int i = 0; i < N_CLASSES; i++) r_cnt[i] <= '0;
      end else if (i_inc_en) begin
         r_cnt[i_inc_cls] <= o_inc_cnt;
      end
   end

endmodule

// File: rtl/knn_vote.sv
// rtl/knn_vote.sv - walks the sorted neighbour list, histograms labels, returns the majority class
module knn_vote
   import knn_vote_pkg::*;
#(
   parameter int HW_K      = 10,
   parameter int LBL_W     = 8,
   parameter int N_CLASSES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [15:0]      n_neighbors,
   output logic [15:0]      SEL,
   input  logic [LBL_W-1:0] LABEL_IN,
   output logic             busy,
   output logic             done,
   output logic [LBL_W-1:0] CLASS_OUT,
   output logic             no_vote
);

   localparam int          CNT_W = clog2_min1(HW_K + 1);
   localparam int          CLS_W = clog2_min1(N_CLASSES);
   localparam logic [31:0] NCLS  = N_CLASSES;

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_kk;
   logic [CNT_W-1:0] r_idx;
   logic [CNT_W-1:0] r_max;
   logic             r_done;
   logic [LBL_W-1:0] r_class;
   logic             r_nv;

   logic             w_valid;
   logic [CLS_W-1:0] w_cls;
   logic [CNT_W-1:0] w_inc_cnt;
   logic [CNT_W-1:0] w_rd_cnt;
   logic [CNT_W-1:0] w_max_next;
   logic [CNT_W-1:0] w_kk_in;
   logic             w_last;

   assign w_valid    = (32'(LABEL_IN) < NCLS);
   assign w_cls      = LABEL_IN[CLS_W-1:0];
   assign w_kk_in    = (n_neighbors > 16'(HW_K)) ? CNT_W'(HW_K) : n_neighbors[CNT_W-1:0];
   assign w_last     = (r_idx == r_kk - CNT_W'(1));
   assign w_max_next = (w_valid && (w_inc_cnt > r_max)) ? w_inc_cnt : r_max;

   knn_class_hist #(
      .N_CLASSES (N_CLASSES),
      .CNT_W     (CNT_W),
      .CLS_W     (CLS_W)
   ) u_hist (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (r_state == ST_CLEAR),
      .i_inc_en  ((r_state == ST_COUNT) && w_valid),
      .i_inc_cls (w_cls),
      .o_inc_cnt (w_inc_cnt),
      .i_rd_cls  (w_cls),
      .o_rd_cnt  (w_rd_cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_kk    <= '0;
         r_idx   <= '0;
         r_max   <= '0;
         r_done  <= 1'b0;
         r_class <= '0;
         r_nv    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_kk <= w_kk_in;
                  if (w_kk_in == '0) begin
                     r_nv    <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= ST_FIN;
                  end else begin
                     r_state <= ST_CLEAR;
                  end
               end
            end
            ST_CLEAR: begin
               r_max   <= '0;
               r_idx   <= '0;
               r_state <= ST_COUNT;
            end
            ST_COUNT: begin
               r_max <= w_max_next;
               if (w_last) begin
                  r_idx <= '0;
                  if (w_max_next == '0) begin
                     r_nv    <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= ST_FIN;
                  end else begin
                     r_state <= ST_PICK;
                  end
               end else begin
                  r_idx <= r_idx + CNT_W'(1);
               end
            end
            ST_PICK: begin
               // Scanning from index 0 makes the nearest tied neighbour win.
               if (w_valid && (w_rd_cnt == r_max)) begin
                  r_class <= LABEL_IN;
                  r_nv    <= 1'b0;
                  r_done  <= 1'b1;
                  r_idx   <= '0;
                  r_state <= ST_FIN;
               end else if (w_last) begin
                  r_nv    <= 1'b1;
                  r_done  <= 1'b1;
                  r_idx   <= '0;
                  r_state <= ST_FIN;
               end else begin
                  r_idx <= r_idx + CNT_W'(1);
               end
            end
            ST_FIN: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_idx   <= '0;
            end
         endcase
      end
   end

   assign SEL       = 16'(r_idx);
   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign CLASS_OUT = r_class;
   assign no_vote   = r_nv;

endmodule

// File: tb/tb_knn_vote.sv
// tb/tb_knn_vote.sv - directed self-checking bench for knn_vote
module tb_knn_vote;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] n_neighbors;
   logic [15:0] SEL;
   logic [7:0]  LABEL_IN;
   logic        busy;
   logic        done;
   logic [7:0]  CLASS_OUT;
   logic        no_vote;

   logic [7:0]  lbl_mem [16];
   logic [15:0] sel_log [64];
   int          checks = 0;
   int          errors = 0;

   knn_vote #(.HW_K(10), .LBL_W(8), .N_CLASSES(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .n_neighbors (n_neighbors),
      .SEL         (SEL),
      .LABEL_IN    (LABEL_IN),
      .busy        (busy),
      .done        (done),
      .CLASS_OUT   (CLASS_OUT),
      .no_vote     (no_vote)
   );

   always #5 clk = ~clk;

   always_comb LABEL_IN = (SEL < 16'd16) ? lbl_mem[SEL[3:0]] : 8'hFF;

   task automatic fill_labels(input logic [7:0] v);
      for (int i = 0; i < 16; i++) lbl_mem[i] = v;
   endtask

   // Issues one start pulse and reports latency (start cycle = 0) and the result at done.
   task automatic do_vote(input int k, output int lat, output logic [7:0] cls,
                          output logic nv, output logic busy_ok);
      lat = -1; cls = 8'hxx; nv = 1'bx; busy_ok = 1'b1;
      @(negedge clk);
      start = 1'b1;
      n_neighbors = k[15:0];
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         sel_log[i] = SEL;
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            lat = i; cls = CLASS_OUT; nv = no_vote;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; n_neighbors = 16'd0;
      repeat (3) @(negedge clk);
      checks += 5;
      if (SEL !== 16'd0)      begin errors++; $display("FAIL reset_sel got %0d want 0", SEL); end
      if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", done); end
      if (CLASS_OUT !== 8'd0) begin errors++; $display("FAIL reset_class got %0d want 0", CLASS_OUT); end
      if (no_vote !== 1'b0)   begin errors++; $display("FAIL reset_novote got %b want 0", no_vote); end
      rst = 1'b0;
   endtask

   task automatic test_majority;
      int lat; logic [7:0] cls; logic nv, bok;
      logic [15:0] exp_sel [8];
      exp_sel = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd0};
      fill_labels(8'd1);
      lbl_mem[0] = 8'd3; lbl_mem[1] = 8'd1; lbl_mem[2] = 8'd3; lbl_mem[3] = 8'd2; lbl_mem[4] = 8'd3;
      do_vote(5, lat, cls, nv, bok);
      checks += 4;
      if (lat !== 8)     begin errors++; $display("FAIL majority_latency got %0d want 8", lat); end
      if (cls !== 8'd3)  begin errors++; $display("FAIL majority_class got %0d want 3", cls); end
      if (nv !== 1'b0)   begin errors++; $display("FAIL majority_novote got %b want 0", nv); end
      if (bok !== 1'b1)  begin errors++; $display("FAIL majority_busy got %b want 1", bok); end
      if (lat == 8) begin
         for (int i = 1; i <= 8; i++) begin
            checks++;
            if (sel_log[i] !== exp_sel[i-1]) begin
               errors++;
               $display("FAIL majority_sel_cycle%0d got %0d want %0d", i, sel_log[i], exp_sel[i-1]);
            end
         end
      end
   endtask

   task automatic test_tie;
      int lat; logic [7:0] cls; logic nv, bok;
      fill_labels(8'd5);
      lbl_mem[0] = 8'd2; lbl_mem[1] = 8'd5; lbl_mem[2] = 8'd5; lbl_mem[3] = 8'd2;
      do_vote(4, lat, cls, nv, bok);
      checks += 3;
      if (lat !== 7)    begin errors++; $display("FAIL tie_latency got %0d want 7", lat); end
      if (cls !== 8'd2) begin errors++; $display("FAIL tie_class got %0d want 2", cls); end
      if (nv !== 1'b0)  begin errors++; $display("FAIL tie_novote got %b want 0", nv); end
   endtask

   task automatic test_clamp;
      int lat; logic [7:0] cls; logic nv, bok;
      fill_labels(8'd9);
      lbl_mem[0] = 8'd200; lbl_mem[1] = 8'd9;   lbl_mem[2] = 8'd200; lbl_mem[3] = 8'd7;
      lbl_mem[4] = 8'd7;   lbl_mem[5] = 8'd200; lbl_mem[6] = 8'd7;   lbl_mem[7] = 8'd1;
      lbl_mem[8] = 8'd200; lbl_mem[9] = 8'd5;
      do_vote(40, lat, cls, nv, bok);
      checks += 3;
      if (lat !== 16)   begin errors++; $display("FAIL clamp_latency got %0d want 16", lat); end
      if (cls !== 8'd7) begin errors++; $display("FAIL clamp_class got %0d want 7", cls); end
      if (nv !== 1'b0)  begin errors++; $display("FAIL clamp_novote got %b want 0", nv); end
   endtask

   task automatic test_no_vote;
      int lat; logic [7:0] cls; logic nv, bok;
      do_vote(0, lat, cls, nv, bok);
      checks += 3;
      if (lat !== 1)    begin errors++; $display("FAIL k0_latency got %0d want 1", lat); end
      if (nv !== 1'b1)  begin errors++; $display("FAIL k0_novote got %b want 1", nv); end
      if (cls !== 8'd7) begin errors++; $display("FAIL k0_class_held got %0d want 7", cls); end
      fill_labels(8'd1);
      lbl_mem[0] = 8'd16; lbl_mem[1] = 8'd255; lbl_mem[2] = 8'd100;
      do_vote(3, lat, cls, nv, bok);
      checks += 3;
      if (lat !== 5)    begin errors++; $display("FAIL invalid_latency got %0d want 5", lat); end
      if (nv !== 1'b1)  begin errors++; $display("FAIL invalid_novote got %b want 1", nv); end
      if (cls !== 8'd7) begin errors++; $display("FAIL invalid_class_held got %0d want 7", cls); end
   endtask

   task automatic test_back_to_back;
      int d1, d2; logic [7:0] c1, c2; logic nv2, bl1, bh2;
      d1 = -1; d2 = -1; c1 = 8'hxx; c2 = 8'hxx; nv2 = 1'bx; bl1 = 1'bx; bh2 = 1'bx;
      fill_labels(8'd1);
      lbl_mem[0] = 8'd4; lbl_mem[1] = 8'd4; lbl_mem[2] = 8'd1;
      @(negedge clk);
      start = 1'b1;
      n_neighbors = 16'd3;
      for (int t = 1; t <= 40; t++) begin
         @(negedge clk);
         if (t == 1) n_neighbors = 16'd0;
         if (t == 3) n_neighbors = 16'd3;
         if (d1 >= 0 && t == d1 + 1) bl1 = busy;
         if (d1 >= 0 && t == d1 + 2) bh2 = busy;
         if (done) begin
            if (d1 < 0) begin
               d1 = t; c1 = CLASS_OUT;
            end else begin
               d2 = t; c2 = CLASS_OUT; nv2 = no_vote;
               start = 1'b0;
               break;
            end
         end
      end
      start = 1'b0;
      checks += 7;
      if (d1 !== 6)     begin errors++; $display("FAIL b2b_first_latency got %0d want 6", d1); end
      if (d2 !== 13)    begin errors++; $display("FAIL b2b_second_done got %0d want 13", d2); end
      if (c1 !== 8'd4)  begin errors++; $display("FAIL b2b_first_class got %0d want 4", c1); end
      if (c2 !== 8'd4)  begin errors++; $display("FAIL b2b_second_class got %0d want 4", c2); end
      if (nv2 !== 1'b0) begin errors++; $display("FAIL b2b_novote got %b want 0", nv2); end
      if (bl1 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got %b want 0", bl1); end
      if (bh2 !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy got %b want 1", bh2); end
   endtask

   task automatic test_reset_mid_vote;
      int lat; logic [7:0] cls; logic nv, bok;
      fill_labels(8'd5);
      @(negedge clk);
      start = 1'b1;
      n_neighbors = 16'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (SEL !== 16'd2) begin errors++; $display("FAIL midrst_sel_before got %0d want 2", SEL); end
      rst = 1'b1;
      #1;
      checks += 4;
      if (busy !== 1'b0)      begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
      if (done !== 1'b0)      begin errors++; $display("FAIL midrst_done got %b want 0", done); end
      if (SEL !== 16'd0)      begin errors++; $display("FAIL midrst_sel got %0d want 0", SEL); end
      if (CLASS_OUT !== 8'd0) begin errors++; $display("FAIL midrst_class got %0d want 0", CLASS_OUT); end
      @(negedge clk);
      rst = 1'b0;
      fill_labels(8'd5);
      lbl_mem[0] = 8'd6; lbl_mem[1] = 8'd5; lbl_mem[2] = 8'd6; lbl_mem[3] = 8'd2; lbl_mem[4] = 8'd2;
      do_vote(5, lat, cls, nv, bok);
      checks += 3;
      if (lat !== 8)    begin errors++; $display("FAIL fresh_latency got %0d want 8", lat); end
      if (cls !== 8'd6) begin errors++; $display("FAIL fresh_class got %0d want 6", cls); end
      if (nv !== 1'b0)  begin errors++; $display("FAIL fresh_novote got %b want 0", nv); end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      n_neighbors = 16'd0;
      fill_labels(8'd0);
      test_reset();
      test_majority();
      test_tie();
      test_clamp();
      test_no_vote();
      test_back_to_back();
      test_reset_mid_vote();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
